// File: rtl/deconv_1d.sv
// deconv_1d: recovers A[0..N-1] from Y = A*B by sequential long division.
// All arithmetic wraps mod 256. A MAC stage removes the contribution of the
// already-recovered samples, and an 8-cycle restoring divider by B[0] then
// yields each new sample. The tail samples Y[N..N+M-2] are checked for a zero
// residual.
module deconv_1d #(
  parameter int unsigned N = 5,
  parameter int unsigned M = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] y,
  input  logic [7:0] b,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       done,
  output logic       err
);

  localparam int unsigned IW = (N + M > 2) ? $clog2(N + M) : 1;
  // Arrays are sized to the full index range so that every select is exactly in range.
  localparam int unsigned Depth   = 2 ** IW;
  localparam logic [IW-1:0] LastIdx = IW'(N + M - 2);
  localparam logic [IW-1:0] NumA    = IW'(N);
  localparam logic [IW-1:0] NumB    = IW'(M);
  localparam logic [IW-1:0] MaxK    = IW'(M - 1);
  localparam logic [IW-1:0] NmOne   = IW'(N - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StMac, StDiv, StEmit, StChk, StDone
  } state_e;

  state_e r_state, w_state_next;

  logic [IW-1:0] r_idx, r_n, r_k;
  logic [7:0]    r_acc;
  logic          r_mac_first;
  logic [7:0]    r_quo, r_rem;
  logic [2:0]    r_cnt;
  logic [7:0]    r_out;
  logic          r_out_valid, r_done, r_err;

  logic [7:0] r_y [Depth];
  logic [7:0] r_b [Depth];
  logic [7:0] r_a [Depth];

  logic [IW-1:0] w_k_lo, w_k_hi, w_a_idx;
  logic          w_mac_empty, w_mac_last;
  logic [7:0]    w_prod;
  logic [7:0]    w_div_src, w_rem_in, w_rem_next, w_quo_next;
  logic [8:0]    w_shift;
  logic          w_ge, w_div_last, w_b0_zero, w_load_cap;

  // Valid tap range for sample n: k in [max(1, n-N+1), min(n, M-1)].
  assign w_k_hi      = (r_n < MaxK) ? r_n : MaxK;
  assign w_k_lo      = (r_n >= NumA) ? (r_n - NmOne) : IW'(1);
  assign w_mac_empty = (w_k_lo > w_k_hi);
  assign w_mac_last  = r_mac_first ? w_mac_empty : (r_k == w_k_hi);
  assign w_a_idx     = r_n - r_k;
  assign w_prod      = r_b[r_k] * r_a[w_a_idx];

  // One restoring-divide step; the first step takes its dividend straight from acc.
  assign w_div_src  = (r_cnt == 3'd0) ? r_acc : r_quo;
  assign w_rem_in   = (r_cnt == 3'd0) ? 8'd0 : r_rem;
  assign w_shift    = {w_rem_in, w_div_src[7]};
  assign w_ge       = (w_shift >= {1'b0, r_b[0]});
  assign w_rem_next = w_ge ? 8'(w_shift - {1'b0, r_b[0]}) : w_shift[7:0];
  assign w_quo_next = {w_div_src[6:0], w_ge};
  assign w_div_last = (r_cnt == 3'd7);
  assign w_b0_zero  = (r_b[0] == 8'd0);
  assign w_load_cap = (r_state == StLoad) && in_valid;

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign err       = r_err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone: if (start) w_state_next = StLoad;
      StLoad:         if (in_valid && (r_idx == LastIdx)) w_state_next = StMac;
      StMac:          if (w_mac_last) w_state_next = (r_n < NumA) ? StDiv : StChk;
      StDiv:          if (w_div_last) w_state_next = StEmit;
      StEmit:         w_state_next = StMac;
      StChk:          w_state_next = (r_n == LastIdx) ? StDone : StMac;
      default:        w_state_next = StIdle;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_acc       <= 8'd0;
      r_mac_first <= 1'b0;
      r_quo       <= 8'd0;
      r_rem       <= 8'd0;
      r_cnt       <= 3'd0;
      r_out       <= 8'd0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_idx  <= '0;
            r_n    <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == LastIdx) begin
              r_n         <= '0;
              r_mac_first <= 1'b1;
            end
          end
        end
        StMac: begin
          r_cnt <= 3'd0;
          if (r_mac_first) begin
            r_acc       <= r_y[r_n];
            // Start at the first valid tap so MAC lasts exactly 1+K cycles.
            r_k         <= w_k_lo;
            r_mac_first <= 1'b0;
          end else begin
            r_acc <= r_acc - w_prod;
            r_k   <= r_k + 1'b1;
          end
        end
        StDiv: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 3'd1;
          if (w_div_last && (w_b0_zero || (w_rem_next != 8'd0))) r_err <= 1'b1;
        end
        StEmit: begin
          r_out       <= r_a[r_n];
          r_out_valid <= 1'b1;
          r_n         <= r_n + 1'b1;
          r_mac_first <= 1'b1;
        end
        StChk: begin
          if (r_acc != 8'd0) r_err <= 1'b1;
          r_n         <= r_n + 1'b1;
          r_mac_first <= 1'b1;
          if (r_n == LastIdx) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sample storage; contents are only meaningful within a job, so no reset.
  always_ff @(posedge clk) begin
    if (w_load_cap) begin
      r_y[r_idx] <= y;
      if (r_idx < NumB) r_b[r_idx] <= b;
    end
    if ((r_state == StDiv) && w_div_last) begin
      r_a[r_n] <= w_b0_zero ? 8'hFF : w_quo_next;
    end
  end

endmodule

// File: tb/tb_deconv_1d.sv
// Bench for deconv_1d: directed scenarios plus randomized jobs against a
// plain-arithmetic long-division model.
module tb_deconv_1d;

  localparam int TN = 5;
  localparam int TM = 3;
  localparam int TL = TN + TM - 1;

  logic       clk;
  logic       rst, start, in_valid;
  logic [7:0] y, b;
  logic [7:0] out;
  logic       out_valid, done, err;

  deconv_1d #(.N(TN), .M(TM)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .y        (y),
    .b        (b),
    .out      (out),
    .out_valid(out_valid),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mon_out[$];
  int         mon_cyc[$];
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      mon_out.push_back(out);
      mon_cyc.push_back(cyc);
    end
  end

  logic [7:0] ty [TL];
  logic [7:0] tbk[TM];
  logic [7:0] exp_a[TN];
  bit         exp_err;
  int         n_vec, n_bad;
  int         base, cap_cyc;
  bit         timed_out;

  // Reference: long division of Y by B, mod 256, with tail residual check.
  task automatic model();
    logic [7:0] acc;
    exp_err = 1'b0;
    for (int n = 0; n < TL; n++) begin
      acc = ty[n];
      for (int k = 1; k < TM && k <= n; k++)
        if (n - k < TN) acc = acc - tbk[k] * exp_a[n-k];
      if (n < TN) begin
        if (tbk[0] == 8'd0) begin
          exp_a[n] = 8'hFF;
          exp_err  = 1'b1;
        end else begin
          exp_a[n] = acc / tbk[0];
          if (acc % tbk[0] != 8'd0) exp_err = 1'b1;
        end
      end else if (acc != 8'd0) begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic set_nominal();
    ty  = '{8'd1, 8'd4, 8'd10, 8'd16, 8'd22, 8'd22, 8'd15};
    tbk = '{8'd1, 8'd2, 8'd3};
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    base = mon_out.size();
  endtask

  task automatic load(input bit gaps);
    for (int i = 0; i < TL; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        y = 8'($urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      y = ty[i];
      b = (i < TM) ? tbk[i] : 8'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cap_cyc  = cyc;
    end
  endtask

  task automatic wait_done();
    timed_out = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; y = 8'd0; b = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out !== 8'd0)     begin n_bad++; $display("FAIL reset_out got %h want 00", out); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov got %b want 0", out_valid); end
    n_vec++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    @(posedge clk); #1 rst = 1'b0;
    cnt = mon_out.size();
    // in_valid outside LOAD must be ignored
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    #1 in_valid = 1'b0;
    n_vec++; if (mon_out.size() !== cnt) begin n_bad++; $display("FAIL idle_strobe got %0d want %0d", mon_out.size(), cnt); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL idle_done got %b want 0", done); end
  endtask

  task automatic test_directed(input string name, input bit gaps, input bit chk_lat);
    do_start();
    load(gaps);
    wait_done();
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done got %b want 1 (timeout=%0b)", name, done, timed_out); end
    n_vec++; if (err !== exp_err) begin n_bad++; $display("FAIL %s_err got %b want %b", name, err, exp_err); end
    n_vec++;
    if (mon_out.size() - base !== TN) begin
      n_bad++; $display("FAIL %s_count got %0d want %0d", name, mon_out.size() - base, TN);
    end
    for (int i = 0; i < TN && base + i < mon_out.size(); i++) begin
      n_vec++;
      if (mon_out[base+i] !== exp_a[i]) begin
        n_bad++; $display("FAIL %s_out[%0d] got %h want %h", name, i, mon_out[base+i], exp_a[i]);
      end
    end
    if (chk_lat && mon_out.size() - base >= 2) begin
      n_vec++; if (mon_cyc[base] - cap_cyc !== 10) begin n_bad++; $display("FAIL %s_lat0 got %0d want 10", name, mon_cyc[base] - cap_cyc); end
      n_vec++; if (mon_cyc[base+1] - cap_cyc !== 21) begin n_bad++; $display("FAIL %s_lat1 got %0d want 21", name, mon_cyc[base+1] - cap_cyc); end
    end
  endtask

  task automatic test_nominal();
    set_nominal();
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; exp_err = 1'b0;
    test_directed("nominal", 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    ty  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd251, 8'd0};
    tbk = '{8'd1, 8'd255, 8'd0};
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; exp_err = 1'b0;
    test_directed("wrap", 1'b0, 1'b0);
  endtask

  task automatic test_tail();
    set_nominal();
    ty[6] = 8'd16;
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; exp_err = 1'b1;
    test_directed("tail", 1'b0, 1'b0);
  endtask

  task automatic test_divfault();
    set_nominal();
    tbk[0] = 8'd0;
    exp_a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}; exp_err = 1'b1;
    test_directed("div0", 1'b0, 1'b0);
    set_nominal();
    tbk = '{8'd2, 8'd0, 8'd0};
    ty[0] = 8'd3;
    model();
    n_vec++; if (exp_a[0] !== 8'd1 || exp_err !== 1'b1) begin n_bad++; $display("FAIL divrem_model got %h/%b want 01/1", exp_a[0], exp_err); end
    test_directed("divrem", 1'b0, 1'b0);
  endtask

  task automatic test_stall_reset();
    bit seen;
    set_nominal();
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; exp_err = 1'b0;
    test_directed("stall", 1'b1, 1'b0);
    do_start();
    load(1'b0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mon_out.size() - base >= 2) begin seen = 1'b1; break; end
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL abort_second_strobe got none want 2 strobes"); end
    // MAC for n=2 takes 3 cycles; land inside the third DIV
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out !== 8'd0)      begin n_bad++; $display("FAIL abort_out got %h want 00", out); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_ov got %b want 0", out_valid); end
    n_vec++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL abort_flags got %b%b want 00", done, err); end
    base = mon_out.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++; if (mon_out.size() !== base) begin n_bad++; $display("FAIL abort_nostrobe got %0d want %0d", mon_out.size(), base); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_idle_done got %b want 0", done); end
    test_directed("fresh", 1'b0, 1'b1);
  endtask

  task automatic test_restart();
    test_tail();
    set_nominal();
    do_start();
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done got %b want 0", done); end
    n_vec++; if (err !== 1'b0)  begin n_bad++; $display("FAIL restart_err got %b want 0", err); end
    load(1'b0);
    wait_done();
    n_vec++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL restart_end got %b%b want 10", done, err); end
    for (int i = 0; i < TN && base + i < mon_out.size(); i++) begin
      n_vec++;
      if (mon_out[base+i] !== 8'(i + 1)) begin
        n_bad++; $display("FAIL restart_out[%0d] got %h want %h", i, mon_out[base+i], 8'(i + 1));
      end
    end
    n_vec++; if (mon_out.size() - base !== TN) begin n_bad++; $display("FAIL restart_count got %0d want %0d", mon_out.size() - base, TN); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < TL; i++) ty[i] = 8'($urandom);
      for (int i = 0; i < TM; i++) tbk[i] = 8'($urandom);
      if (it % 5 == 0) tbk[0] = 8'd0;
      if (it % 3 == 0) tbk[0] = 8'd1;
      model();
      test_directed("rand", 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_nominal();
    test_wrap();
    test_tail();
    test_divfault();
    test_stall_reset();
    test_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
